bisc_sequencer: RTL and testbench
=================================

# bisc_sequencer

Control stage directly upstream of `processing_element`. It accepts one unsigned operand `x` and an accumulator preload value over a valid/ready handshake, then drives a `processing_element` over a bit-serial pass. During the pass it generates the PE's `init`, `enable`, `selector` and `zero_select` inputs, so the PE counter accumulates approximately x·w/2^`BIN_LEN`. At the end it holds a result-valid handshake until the consumer accepts. One sequencer may drive a row of PEs that share selector timing.

## Interface
- `BIN_LEN`, from `sys_defs.svh`: operand/weight width N.
- `BIN_WIDTH`, from `sys_defs.svh`: selector width, log2(`BIN_LEN`).
- `OUT_BIN_LEN`, from `sys_defs.svh`: PE accumulator width.
- `FIXED_LENGTH`, default 0: 0 means the pass lasts x cycles; 1 means the pass always lasts 2^N−1 cycles, with padding cycles zero-gated.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `in_valid`  in  1  operand offer.
- `in_ready`  out  1  high only in IDLE.
- `x_val`  in  `BIN_LEN`  unsigned operand x.
- `bias_val`  in  `OUT_BIN_LEN`  accumulator preload.
- `pe_init`  out  1  to PE `init`.
- `pe_enable`  out  1  to PE `enable`.
- `pe_init_val`  out  `OUT_BIN_LEN`  latched `bias_val`, to PE `init_val`.
- `selector`  out  `BIN_WIDTH`  to PE `selector`.
- `zero_select`  out  1  to PE `zero_select`; 1 forces the mux bit to 0.
- `out_valid`  out  1  PE count is final and stable.
- `out_ready`  in  1  consumer accepts the result.

## Operation
- FSM states: IDLE, INIT, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - When `in_valid`=1, latch x and bias, set step k=1, go to INIT.
- **INIT** (1 cycle)
  - `pe_init`=1, `pe_enable`=1, `zero_select`=1.
  - Run length L = x when `FIXED_LENGTH`=0, else 2^N−1.
  - L=0 goes to DONE; otherwise go to RUN.
- **RUN** (L cycles)
  - `pe_enable`=1.
  - `selector` = N−1−tz(k), where tz is the count of trailing zeros of k. Example for N=8, k=1,2,3,4 → 7,6,7,5.
  - `zero_select` = (k > x).
  - k increments each cycle. The cycle with k==L goes to DONE.
- **DONE**
  - `out_valid`=1, `pe_enable`=0, so the PE count is held.
  - When `out_ready`=1, go to IDLE.
- Range and width rules:
  - k ≤ 2^N−1, so tz(k) ≤ N−1 and `selector` never underflows.
  - k is `BIN_LEN` bits wide and never wraps.
- Outside RUN: `selector`=0, `zero_select`=1, `pe_init`=0 except in INIT.
- `pe_init_val` holds the last latched bias and updates only on acceptance.
- No new operand is accepted before the DONE handshake completes, so there is no accept/complete overlap.

## Timing
- Reset values: state IDLE, `in_ready`=1, `pe_init`=0, `pe_enable`=0, `selector`=0, `zero_select`=1, `out_valid`=0, `pe_init_val`=0, k=0.
- All outputs decode from registered state and k only. There is no combinational input→output path.
- Cycle sequence, with cycle 0 being the cycle in which `in_valid`&`in_ready` is sampled:
  - INIT in cycle 1.
  - RUN in cycles 2…L+1.
  - `out_valid` first high in cycle L+2.
- `in_ready` returns high the cycle after the `out_valid`&`out_ready` handshake.
- Reset asserted mid-pass returns the block to the reset values immediately. The PE result is discarded.
- `out_valid` stays high and stable indefinitely while `out_ready`=0.

## Structure
- Add to the shared defines:
  - State encoding typedef `bisc_seq_state_t`.
  - Constant `BISC_MAX_STEPS` = 2^`BIN_LEN`−1.
- Sub-module `trailing_zero_encoder`: combinational, `BIN_LEN` in → `BIN_WIDTH` out. It computes tz(k); an input of 0 gives 0.
- The FSM, the step counter and the operand/bias registers live in `bisc_sequencer`.

## Test plan
All scenarios use N=8.
- **x=5, `FIXED_LENGTH`=0:** one INIT cycle, then 5 RUN cycles with `selector` 7,6,7,5,7 and `zero_select`=0. `out_valid` appears in cycle 7.
- **x=0:** INIT followed directly by DONE with no RUN cycles. `out_valid` appears in cycle 2. The PE holds `bias_val`.
- **x=3, `FIXED_LENGTH`=1:** 255 RUN cycles. `zero_select`=0 for k=1..3 and 1 for k=4..255. `selector`=0 exactly at k=128.
- **End-to-end with a PE:** w=0xFF, x=255, bias=10 → final PE count 265. w=0x80, x=200 → count 100.
- **Backpressure:** hold `out_ready`=0 for 4 cycles in DONE. `out_valid`, `pe_enable`=0 and `in_ready`=0 hold throughout. `in_valid` asserted during DONE is ignored.
- **Reset pulse at RUN k=3:** outputs immediately return to the reset values. A new x=2 accepted afterwards runs `selector` 7,6 normally.

Source files
------------

// File: rtl/bisc_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bisc_sequencer_pkg : shared widths, state encoding and step limit  (rev 1.0)
// ---------------------------------------------------------------------------
package bisc_sequencer_pkg;

    localparam int BIN_LEN     = 8;
    localparam int BIN_WIDTH   = $clog2(BIN_LEN);
    localparam int OUT_BIN_LEN = 16;

    localparam logic [BIN_LEN-1:0] BISC_MAX_STEPS = {BIN_LEN{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } bisc_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/bisc_sequencer_trailing_zero_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trailing_zero_encoder : count of trailing zeros, zero input gives 0  (rev 1.0)
// ---------------------------------------------------------------------------
module trailing_zero_encoder
    import bisc_sequencer_pkg::*;
(
    input  logic [BIN_LEN-1:0]   value,
    output logic [BIN_WIDTH-1:0] count
);

    // Scan from the MSB down so the lowest set bit is the last one to win.
    always_comb begin
        count = '0;
        for (int i = BIN_LEN - 1; i >= 0; i--) begin
            if (value[i]) begin
                count = BIN_WIDTH'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bisc_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bisc_sequencer : drives a bit-serial processing element for one operand  (rev 1.0)
// ---------------------------------------------------------------------------
module bisc_sequencer
    import bisc_sequencer_pkg::*;
#(
    parameter int FIXED_LENGTH = 0
)
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BIN_LEN-1:0]     x_val,
    input  logic [OUT_BIN_LEN-1:0] bias_val,
    output logic                   pe_init,
    output logic                   pe_enable,
    output logic [OUT_BIN_LEN-1:0] pe_init_val,
    output logic [BIN_WIDTH-1:0]   selector,
    output logic                   zero_select,
    output logic                   out_valid,
    input  logic                   out_ready
);

    bisc_seq_state_t        state;
    bisc_seq_state_t        state_next;
    logic [BIN_LEN-1:0]     step;
    logic [BIN_LEN-1:0]     step_next;
    logic [BIN_LEN-1:0]     x_reg;
    logic [OUT_BIN_LEN-1:0] bias_reg;
    logic [BIN_LEN-1:0]     run_len;
    logic [BIN_WIDTH-1:0]   step_tz;
    logic                   accept;

    trailing_zero_encoder u_tze (
        .value (step),
        .count (step_tz)
    );

    assign run_len     = (FIXED_LENGTH != 0) ? BISC_MAX_STEPS : x_reg;
    assign accept      = (state == ST_IDLE) && in_valid;
    assign pe_init_val = bias_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            step     <= '0;
            x_reg    <= '0;
            bias_reg <= '0;
        end else begin
            state <= state_next;
            step  <= step_next;
            if (accept) begin
                x_reg    <= x_val;
                bias_reg <= bias_val;
            end
        end
    end

    always_comb begin
        state_next  = state;
        step_next   = step;
        in_ready    = 1'b0;
        pe_init     = 1'b0;
        pe_enable   = 1'b0;
        selector    = '0;
        zero_select = 1'b1;
        out_valid   = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ST_INIT;
                    step_next  = BIN_LEN'(1);
                end
            end
            ST_INIT: begin
                pe_init    = 1'b1;
                pe_enable  = 1'b1;
                state_next = (run_len == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                // Finer weight bits are visited at proportionally lower rates.
                pe_enable   = 1'b1;
                selector    = BIN_WIDTH'(BIN_LEN - 1) - step_tz;
                zero_select = (step > x_reg);
                if (step == run_len) begin
                    state_next = ST_DONE;
                end else begin
                    step_next = step + 1'b1;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                    step_next  = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                step_next  = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_bisc_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bisc_sequencer : bench for bisc_sequencer, variable and fixed length  (rev 1.0)
// ---------------------------------------------------------------------------
module tb_bisc_sequencer;
    import bisc_sequencer_pkg::*;

    typedef struct packed {
        logic       ir;
        logic       init;
        logic       en;
        logic [2:0] sel;
        logic       zs;
        logic       ov;
    } obs_t;

    typedef struct {
        logic [7:0]  x;
        logic [15:0] bias;
        logic [7:0]  w;
        bit          fixed;
        int          exp_done;
        int          exp_count;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  x_val = '0;
    logic [15:0] bias_val = '0;
    logic        out_ready = 1'b1;
    logic        use_b = 1'b0;
    logic [7:0]  w_reg = '0;

    logic        a_in_ready, a_pe_init, a_pe_enable, a_zero_select, a_out_valid;
    logic [15:0] a_pe_init_val;
    logic [2:0]  a_selector;
    logic        b_in_ready, b_pe_init, b_pe_enable, b_zero_select, b_out_valid;
    logic [15:0] b_pe_init_val;
    logic [2:0]  b_selector;

    logic        m_in_ready, m_pe_init, m_pe_enable, m_zero_select, m_out_valid;
    logic [15:0] m_pe_init_val;
    logic [2:0]  m_selector;
    logic [15:0] pe_count;
    obs_t        act;

    int checks = 0;
    int errors = 0;
    obs_t exp_q[$];

    always #5 clock = ~clock;

    bisc_sequencer #(.FIXED_LENGTH(0)) u_dut_var (
        .clock(clock), .reset(reset), .in_valid(in_valid & ~use_b), .in_ready(a_in_ready),
        .x_val(x_val), .bias_val(bias_val), .pe_init(a_pe_init), .pe_enable(a_pe_enable),
        .pe_init_val(a_pe_init_val), .selector(a_selector), .zero_select(a_zero_select),
        .out_valid(a_out_valid), .out_ready(out_ready)
    );

    bisc_sequencer #(.FIXED_LENGTH(1)) u_dut_fix (
        .clock(clock), .reset(reset), .in_valid(in_valid & use_b), .in_ready(b_in_ready),
        .x_val(x_val), .bias_val(bias_val), .pe_init(b_pe_init), .pe_enable(b_pe_enable),
        .pe_init_val(b_pe_init_val), .selector(b_selector), .zero_select(b_zero_select),
        .out_valid(b_out_valid), .out_ready(out_ready)
    );

    assign m_in_ready    = use_b ? b_in_ready    : a_in_ready;
    assign m_pe_init     = use_b ? b_pe_init     : a_pe_init;
    assign m_pe_enable   = use_b ? b_pe_enable   : a_pe_enable;
    assign m_pe_init_val = use_b ? b_pe_init_val : a_pe_init_val;
    assign m_selector    = use_b ? b_selector    : a_selector;
    assign m_zero_select = use_b ? b_zero_select : a_zero_select;
    assign m_out_valid   = use_b ? b_out_valid   : a_out_valid;
    assign act = '{ir: m_in_ready, init: m_pe_init, en: m_pe_enable,
                   sel: m_selector, zs: m_zero_select, ov: m_out_valid};

    // Behavioural bit-serial PE: counts selected weight bits onto the preload.
    always @(posedge clock) begin
        if (m_pe_init)
            pe_count <= m_pe_init_val;
        else if (m_pe_enable)
            pe_count <= pe_count + ((m_zero_select) ? 16'd0 : {15'd0, w_reg[m_selector]});
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic push_expected(input logic [7:0] x, input bit fixed);
        int len;
        len = fixed ? 255 : int'(x);
        exp_q.push_back('{ir: 1'b0, init: 1'b1, en: 1'b1, sel: 3'd0, zs: 1'b1, ov: 1'b0});
        for (int k = 1; k <= len; k++) begin
            int t;
            int v;
            t = 0;
            v = k;
            while ((v % 2) == 0 && t < 7) begin
                v = v / 2;
                t++;
            end
            exp_q.push_back('{ir: 1'b0, init: 1'b0, en: 1'b1, sel: 3'(7 - t),
                              zs: (k > int'(x)), ov: 1'b0});
        end
        exp_q.push_back('{ir: 1'b0, init: 1'b0, en: 1'b0, sel: 3'd0, zs: 1'b1, ov: 1'b1});
    endtask

    // Entered and left at a falling edge with the selected DUT idle.
    task automatic run_vec(input vec_t v);
        int   cyc;
        int   first_ov;
        obs_t e;
        use_b     = v.fixed;
        w_reg     = v.w;
        x_val     = v.x;
        bias_val  = v.bias;
        out_ready = 1'b1;
        check("accept_ready", {31'd0, m_in_ready}, 32'd1);
        in_valid = 1'b1;
        push_expected(v.x, v.fixed);
        @(posedge clock);
        #1 in_valid = 1'b0;
        cyc      = 0;
        first_ov = -1;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            cyc++;
            e = exp_q.pop_front();
            check("cycle_outputs", {24'd0, act}, {24'd0, e});
            if (act.ov && first_ov < 0) first_ov = cyc;
            if (e.ov) check("pe_count", {16'd0, pe_count}, v.exp_count);
        end
        check("done_cycle", first_ov, v.exp_done);
        @(negedge clock);
        check("back_idle", {30'd0, m_in_ready, m_out_valid}, 32'd2);
    endtask

    vec_t vecs[7];
    obs_t reset_obs;
    logic [15:0] held_count;

    initial begin
        reset_obs = '{ir: 1'b1, init: 1'b0, en: 1'b0, sel: 3'd0, zs: 1'b1, ov: 1'b0};
        //           x       bias      w      fixed done count
        vecs[0] = '{8'd5,   16'd0,    8'hA5, 1'b0, 7,   4};
        vecs[1] = '{8'd0,   16'd1234, 8'hFF, 1'b0, 2,   1234};
        vecs[2] = '{8'd255, 16'd10,   8'hFF, 1'b0, 257, 265};
        vecs[3] = '{8'd200, 16'd0,    8'h80, 1'b0, 202, 100};
        vecs[4] = '{8'd3,   16'd0,    8'hFF, 1'b1, 257, 3};
        vecs[5] = '{8'd7,   16'd5,    8'h01, 1'b0, 9,   5};
        vecs[6] = '{8'd0,   16'd77,   8'hFF, 1'b1, 257, 77};

        #3;
        check("reset_var", {24'd0, act}, {24'd0, reset_obs});
        check("reset_fix", {24'd0, b_in_ready, b_pe_init, b_pe_enable, b_selector,
                            b_zero_select, b_out_valid}, {24'd0, reset_obs});
        check("reset_init_val", {16'd0, a_pe_init_val}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Backpressure: DONE held for four cycles, in_valid ignored meanwhile.
        use_b     = 1'b0;
        w_reg     = 8'h80;
        x_val     = 8'd1;
        bias_val  = 16'd3;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clock);
        held_count = pe_count;
        check("bp_count", {16'd0, held_count}, 32'd4);
        in_valid = 1'b1;
        x_val    = 8'd9;
        for (int i = 0; i < 4; i++) begin
            check("bp_hold", {29'd0, m_out_valid, m_pe_enable, m_in_ready}, 32'b100);
            check("bp_count_hold", {16'd0, pe_count}, {16'd0, held_count});
            if (i < 3) @(negedge clock);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clock);
        check("bp_release", {24'd0, act}, {24'd0, reset_obs});
        @(negedge clock);
        check("bp_no_accept", {24'd0, act}, {24'd0, reset_obs});

        // Reset pulse at RUN k=3 of an x=5 pass.
        x_val    = 8'd5;
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clock);
        check("pre_reset_run", {28'd0, m_pe_enable, m_selector}, {28'd0, 1'b1, 3'd7});
        reset = 1'b0;
        #1;
        check("mid_reset", {24'd0, act}, {24'd0, reset_obs});
        check("mid_reset_init_val", {16'd0, m_pe_init_val}, 32'd0);
        @(negedge clock);
        check("reset_hold", {24'd0, act}, {24'd0, reset_obs});
        reset = 1'b1;
        @(negedge clock);
        run_vec('{8'd2, 16'd0, 8'h40, 1'b0, 4, 1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
